// File: rtl/counter_pkg.sv
// Shared opcodes, sequencer state and command payload for the Counter command path.
package counter_pkg;

    localparam int unsigned OP_W       = 3;
    localparam int unsigned CMD_DATA_W = 4;
    localparam int unsigned CMD_DUR_W  = 8;

    localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
    localparam logic [OP_W-1:0] OP_HOLD = 3'd2;
    localparam logic [OP_W-1:0] OP_UP   = 3'd3;
    localparam logic [OP_W-1:0] OP_DOWN = 3'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [OP_W-1:0]       opcode;
        logic [CMD_DATA_W-1:0] data;
        logic [CMD_DUR_W-1:0]  dur;
    } cmd_t;

    // Opcodes the Counter does not define are issued as a harmless hold.
    function automatic logic [OP_W-1:0] filter_op(input logic [OP_W-1:0] op);
        return (op > OP_DOWN) ? OP_HOLD : op;
    endfunction

endpackage

// File: rtl/counter_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy; clear flushes all entries.
module cmd_fifo
    import counter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = cmd_t
) (
    input  logic   clk,
    input  logic   reset_sync,
    input  logic   clear,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rdata   = mem[rd_ptr];

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_sync || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Buffers timed commands and replays each onto the Counter opcode/data inputs
// for a fixed number of cycles, or until the Counter raises y.
module counter_cmd_sequencer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CMD_DATA_W,
    parameter int unsigned DUR_W = CMD_DUR_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [WIDTH-1:0] in_data,
    input  logic [DUR_W-1:0] in_dur,
    input  logic             y,
    output logic [2:0]       opcode,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done
);

    cmd_t             push_cmd;
    cmd_t             head;
    logic             full;
    logic             empty;
    logic             pop_c;
    logic             finish_c;

    seq_state_e       state, state_d;
    logic [2:0]       opcode_d;
    logic [WIDTH-1:0] data_d;
    logic             busy_d;
    logic             done_d;
    logic [DUR_W-1:0] timer, timer_d;

    assign push_cmd = '{opcode: in_opcode, data: in_data, dur: in_dur};
    assign in_ready = !full;

    cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (cmd_t)
    ) u_fifo (
        .clk        (clk),
        .reset_sync (reset_sync),
        .clear      (abort),
        .push       (in_valid && !full && !abort),
        .wdata      (push_cmd),
        .pop        (pop_c),
        .rdata      (head),
        .full       (full),
        .empty      (empty)
    );

    // A timer of 0 marks a wait-for-y command; timed commands end when it reaches 1.
    always_comb begin
        state_d  = state;
        opcode_d = opcode;
        data_d   = data;
        busy_d   = busy;
        done_d   = 1'b0;
        timer_d  = timer;
        pop_c    = 1'b0;
        finish_c = 1'b0;

        case (state)
            IDLE: begin
                opcode_d = OP_HOLD;
                busy_d   = 1'b0;
                if (!empty) begin
                    pop_c    = 1'b1;
                    opcode_d = filter_op(head.opcode);
                    data_d   = head.data;
                    timer_d  = head.dur;
                    busy_d   = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                finish_c = (timer == '0) ? y : (timer == DUR_W'(1));
                if (finish_c) begin
                    done_d = 1'b1;
                    if (!empty) begin
                        pop_c    = 1'b1;
                        opcode_d = filter_op(head.opcode);
                        data_d   = head.data;
                        timer_d  = head.dur;
                    end else begin
                        opcode_d = OP_HOLD;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
                end else if (timer != '0) begin
                    timer_d = timer - DUR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d  = IDLE;
            opcode_d = OP_HOLD;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            pop_c    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_sync) begin
            state  <= IDLE;
            opcode <= OP_HOLD;
            data   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            timer  <= '0;
        end else begin
            state  <= state_d;
            opcode <= opcode_d;
            data   <= data_d;
            busy   <= busy_d;
            done   <= done_d;
            timer  <= timer_d;
        end
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer with hand-computed per-cycle expectations.
module tb_counter_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset_sync;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [3:0] in_data;
    logic [7:0] in_dur;
    logic       y;
    logic [2:0] opcode;
    logic [3:0] data;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    counter_cmd_sequencer #(.WIDTH(4), .DUR_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_data    (in_data),
        .in_dur     (in_dur),
        .y          (y),
        .opcode     (opcode),
        .data       (data),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] op, input logic [3:0] d, input logic [7:0] dur);
        in_valid  = 1'b1;
        in_opcode = op;
        in_data   = d;
        in_dur    = dur;
    endtask

    task automatic no_offer();
        in_valid  = 1'b0;
        in_opcode = 3'd0;
        in_data   = 4'd0;
        in_dur    = 8'd0;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] op, input logic [3:0] d,
                           input logic b, input logic dn);
        chk({tag, ".op"},   32'(opcode), 32'(op));
        chk({tag, ".data"}, 32'(data),   32'(d));
        chk({tag, ".busy"}, 32'(busy),   32'(b));
        chk({tag, ".done"}, 32'(done),   32'(dn));
    endtask

    task automatic do_reset();
        reset_sync = 1'b0;
        tick();
        tick();
        reset_sync = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        abort = 1'b0;
        y     = 1'b0;
        no_offer();
        do_reset();

        // Reset state
        chk_out("rst", 3'd2, 4'd0, 1'b0, 1'b0);
        chk("rst.ready", 32'(in_ready), 32'd1);

        // Single command {LOAD,2,3}
        offer(3'd1, 4'd2, 8'd3); tick(); no_offer();
        chk_out("s1.t0", 3'd2, 4'd0, 1'b0, 1'b0);
        tick(); chk_out("s1.c1", 3'd1, 4'd2, 1'b1, 1'b0);
        tick(); chk_out("s1.c2", 3'd1, 4'd2, 1'b1, 1'b0);
        tick(); chk_out("s1.c3", 3'd1, 4'd2, 1'b1, 1'b0);
        tick(); chk_out("s1.end", 3'd2, 4'd2, 1'b0, 1'b1);
        tick(); chk_out("s1.idle", 3'd2, 4'd2, 1'b0, 1'b0);

        // Back-to-back, the third push coincides with a pop
        offer(3'd1, 4'd2, 8'd1); tick();
        offer(3'd3, 4'd0, 8'd5); tick(); chk_out("bb.1", 3'd1, 4'd2, 1'b1, 1'b0);
        offer(3'd2, 4'd0, 8'd2); tick(); chk_out("bb.2", 3'd3, 4'd0, 1'b1, 1'b1);
        no_offer();
        for (int i = 0; i < 4; i++) begin
            tick(); chk_out($sformatf("bb.up%0d", i), 3'd3, 4'd0, 1'b1, 1'b0);
        end
        tick(); chk_out("bb.7", 3'd2, 4'd0, 1'b1, 1'b1);
        tick(); chk_out("bb.8", 3'd2, 4'd0, 1'b1, 1'b0);
        tick(); chk_out("bb.end", 3'd2, 4'd0, 1'b0, 1'b1);
        tick(); chk_out("bb.idle", 3'd2, 4'd0, 1'b0, 1'b0);

        // Full FIFO behind a long command; fifth push refused
        offer(3'd3, 4'd1, 8'd20); tick(); no_offer();
        tick(); chk_out("ff.long", 3'd3, 4'd1, 1'b1, 1'b0);
        offer(3'd1, 4'hA, 8'd1); chk("ff.rdy0", 32'(in_ready), 32'd1); tick();
        offer(3'd4, 4'hB, 8'd1); chk("ff.rdy1", 32'(in_ready), 32'd1); tick();
        offer(3'd0, 4'hC, 8'd1); chk("ff.rdy2", 32'(in_ready), 32'd1); tick();
        offer(3'd3, 4'hD, 8'd1); chk("ff.rdy3", 32'(in_ready), 32'd1); tick();
        chk("ff.full", 32'(in_ready), 32'd0);
        offer(3'd1, 4'hF, 8'd1); tick(); no_offer();
        chk("ff.full2", 32'(in_ready), 32'd0);
        for (int i = 0; i < 14; i++) tick();
        chk_out("ff.lastlong", 3'd3, 4'd1, 1'b1, 1'b0);
        tick(); chk_out("ff.p1", 3'd1, 4'hA, 1'b1, 1'b1);
        chk("ff.rdyback", 32'(in_ready), 32'd1);
        tick(); chk_out("ff.p2", 3'd4, 4'hB, 1'b1, 1'b1);
        tick(); chk_out("ff.p3", 3'd0, 4'hC, 1'b1, 1'b1);
        tick(); chk_out("ff.p4", 3'd3, 4'hD, 1'b1, 1'b1);
        tick(); chk_out("ff.end", 3'd2, 4'hD, 1'b0, 1'b1);
        tick(); chk_out("ff.idle", 3'd2, 4'hD, 1'b0, 1'b0);

        // Wait-for-y, y sampled high at the seventh edge
        offer(3'd3, 4'd0, 8'd0); tick(); no_offer();
        for (int i = 1; i <= 6; i++) begin
            tick(); chk_out($sformatf("wy.c%0d", i), 3'd3, 4'd0, 1'b1, 1'b0);
        end
        y = 1'b1;
        tick(); y = 1'b0;
        chk_out("wy.end", 3'd2, 4'd0, 1'b0, 1'b1);

        // Wait-for-y with y already high: one held cycle
        y = 1'b1;
        offer(3'd4, 4'd3, 8'd0); tick(); no_offer();
        tick(); chk_out("wy1.c1", 3'd4, 4'd3, 1'b1, 1'b0);
        tick(); chk_out("wy1.end", 3'd2, 4'd3, 1'b0, 1'b1);
        y = 1'b0;
        tick();

        // Maximum duration, no wrap
        offer(3'd3, 4'd6, 8'd255); tick(); no_offer();
        tick(); chk_out("max.c1", 3'd3, 4'd6, 1'b1, 1'b0);
        for (int i = 0; i < 254; i++) tick();
        chk_out("max.c255", 3'd3, 4'd6, 1'b1, 1'b0);
        tick(); chk_out("max.end", 3'd2, 4'd6, 1'b0, 1'b1);
        tick();

        // Abort mid-HOLD with two queued and a same-edge push
        offer(3'd3, 4'd1, 8'd10); tick();
        offer(3'd1, 4'd7, 8'd2); tick();
        offer(3'd4, 4'd8, 8'd2); tick(); no_offer();
        tick(); chk("ab.pre", 32'(busy), 32'd1);
        abort = 1'b1; offer(3'd1, 4'd9, 8'd2); tick();
        abort = 1'b0; no_offer();
        chk("ab.op", 32'(opcode), 32'd2);
        chk("ab.busy", 32'(busy), 32'd0);
        chk("ab.done", 32'(done), 32'd0);
        chk("ab.ready", 32'(in_ready), 32'd1);
        tick(); tick();
        chk("ab.empty.op", 32'(opcode), 32'd2);
        chk("ab.empty.busy", 32'(busy), 32'd0);

        // Reset mid-HOLD with two queued
        offer(3'd1, 4'd9, 8'd10); tick();
        offer(3'd3, 4'd4, 8'd2); tick();
        offer(3'd4, 4'd5, 8'd2); tick(); no_offer();
        tick(); chk("rs.pre", 32'(busy), 32'd1);
        reset_sync = 1'b0; abort = 1'b1; tick();
        reset_sync = 1'b1; abort = 1'b0;
        chk_out("rs.post", 3'd2, 4'd0, 1'b0, 1'b0);
        chk("rs.ready", 32'(in_ready), 32'd1);
        tick(); tick();
        chk_out("rs.empty", 3'd2, 4'd0, 1'b0, 1'b0);

        // Illegal opcode issued as HOLD with its data and duration
        offer(3'd7, 4'd5, 8'd2); tick(); no_offer();
        tick(); chk_out("il.c1", 3'd2, 4'd5, 1'b1, 1'b0);
        tick(); chk_out("il.c2", 3'd2, 4'd5, 1'b1, 1'b0);
        tick(); chk_out("il.end", 3'd2, 4'd5, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
